// File: rtl/tile_pkg.sv
// tile_pkg: tile-map geometry, the queued update record and the writer FSM states.
package tile_pkg;
    localparam int TILES     = 4800;
    localparam int TILE_COLS = 80;
    localparam int TILE_ROWS = 60;
    localparam int ADDR_W    = 13;
    localparam int ID_W      = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   tile;
    } tile_upd_t;

    typedef enum logic [1:0] {IDLE, ARMED, ISSUE} tw_state_e;
endpackage

// File: rtl/tile_fifo.sv
// tile_fifo: DEPTH-entry FIFO of tile updates; read data is the current head, combinationally.
module tile_fifo
    import tile_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  tile_upd_t              wdata,
    output tile_upd_t              rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    tile_upd_t     mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign level   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = do_pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/tile_update_writer.sv
// tile_update_writer: queues tile updates and writes them to the display bus at the start of vblank.
// Define TILE_WRITER_STATS_EN to count discarded out-of-range requests in drop_count.
module tile_update_writer
    import tile_pkg::ADDR_W, tile_pkg::ID_W, tile_pkg::tile_upd_t, tile_pkg::tw_state_e;
    import tile_pkg::IDLE, tile_pkg::ARMED, tile_pkg::ISSUE;
#(
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 256,
    parameter int TILES     = 4800
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [12:0]            in_addr,
    input  logic [5:0]             in_tile,
    input  logic                   vga_vs,
    output logic                   chipselect,
    output logic                   write,
    output logic [12:0]            address,
    output logic [15:0]            writedata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic [15:0]            drop_count
);
    localparam int CW = $clog2(MAX_BURST + 1);

    tw_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ID_W-1:0]   tile_q, tile_d;
    logic              cs_q, vs_q, rdy_q;
    logic              full, empty, push, pop, vb_start;
    tile_upd_t         head;

    assign in_ready   = rdy_q && !full;
    assign push       = in_valid && in_ready && (in_addr < ADDR_W'(TILES));
    assign vb_start   = vs_q && !vga_vs;
    assign chipselect = cs_q;
    assign write      = cs_q;
    assign address    = addr_q;
    assign writedata  = {10'b0, tile_q};
    assign busy       = !empty || state_q != IDLE;

    tile_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({in_addr, in_tile}),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // The first pop happens on the vb_start edge itself so the strobe follows in the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  state_d = empty ? IDLE : ARMED;
            ARMED: if (vb_start) begin
                state_d = ISSUE;
                pop     = 1'b1;
                cnt_d   = CW'(1);
            end
            ISSUE: if (empty) state_d = IDLE;
                   else if (cnt_q == CW'(MAX_BURST)) state_d = ARMED;
                   else begin
                       pop   = 1'b1;
                       cnt_d = cnt_q + CW'(1);
                   end
            default: state_d = IDLE;
        endcase
        addr_d = pop ? head.addr : addr_q;
        tile_d = pop ? head.tile : tile_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            tile_q  <= '0;
            cs_q    <= 1'b0;
            vs_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            tile_q  <= tile_d;
            cs_q    <= pop;
            vs_q    <= vga_vs;
            rdy_q   <= 1'b1;
        end
    end

`ifdef TILE_WRITER_STATS_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = (in_valid && in_ready && in_addr >= ADDR_W'(TILES) && drop_q != 16'hFFFF)
                 ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_tile_update_writer.sv
// tb_tile_update_writer: directed bench with a bus-write scoreboard, DUT built with MAX_BURST = 4.
module tb_tile_update_writer;
    logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, vga_vs = 1'b1;
    logic [12:0] in_addr = '0;
    logic [5:0]  in_tile = '0;
    logic        in_ready, chipselect, write, busy;
    logic [12:0] address;
    logic [15:0] writedata, drop_count;
    logic [4:0]  level;

    int          n_cmp = 0, n_bad = 0, wr_cnt = 0, drop_exp = 0, n = 0, w0 = 0;
    logic [30:0] sb[$], got[$];

    always #10 clk = ~clk;

    tile_update_writer #(.DEPTH(16), .MAX_BURST(4), .TILES(4800)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_tile    (in_tile),
        .vga_vs     (vga_vs),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .level      (level),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always @(negedge clk) begin
        if (chipselect || write) begin
            got.push_back({chipselect, write, address, writedata});
            wr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [12:0] a, input logic [5:0] t);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_addr  = a;
        in_tile  = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("push_accepted", 32'(ok), 1);
        if (ok && a < 13'd4800) sb.push_back({2'b11, a, 10'b0, t});
    endtask

    task automatic frame(output int nw);
        int start = wr_cnt;
        vga_vs = 1'b0;
        step();
        vga_vs = 1'b1;
        repeat (8) step();
        nw = wr_cnt - start;
    endtask

    task automatic drain_cmp();
        logic [30:0] g, e;
        while (got.size() > 0) begin
            g = got.pop_front();
            if (sb.size() > 0) e = sb.pop_front();
            else e = '0;
            chk("bus_write", {1'b0, g}, {1'b0, e});
        end
    endtask

    initial begin
        #25;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cs", chipselect, 0);
        chk("rst_write", write, 0);
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        step();
        reset_n = 1'b1;
        chk("rdy_before_edge", in_ready, 0);
        step();
        chk("rdy_after_edge", in_ready, 1);

        // three queued writes released by one vblank start
        push(13'd5, 6'd23);
        push(13'd80, 6'd12);
        push(13'd4799, 6'd8);
        repeat (3) step();
        chk("t1_no_strobe", wr_cnt, 0);
        chk("t1_level", level, 3);
        chk("t1_busy", busy, 1);
        vga_vs = 1'b0;
        step();
        chk("t1_cs0", chipselect, 1);
        vga_vs = 1'b1;
        step();
        chk("t1_cs1", chipselect, 1);
        step();
        chk("t1_cs2", chipselect, 1);
        step();
        chk("t1_cs_off", chipselect, 0);
        chk("t1_write_off", write, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_addr_hold", address, 4799);
        chk("t1_data_hold", writedata, 8);
        chk("t1_wr_cnt", wr_cnt, 3);
        drain_cmp();

        // fill the queue, hold a 17th request until the first pop
        for (int i = 0; i < 16; i++) push(13'(i * 300), 6'(i % 41));
        chk("t2_full_ready", in_ready, 0);
        chk("t2_full_level", level, 16);
        in_valid = 1'b1;
        in_addr  = 13'd1234;
        in_tile  = 6'd40;
        repeat (3) step();
        chk("t2_refused_level", level, 16);
        chk("t2_refused_ready", in_ready, 0);
        vga_vs = 1'b0;
        step();
        vga_vs = 1'b1;
        chk("t2_pop_level", level, 15);
        chk("t2_pop_ready", in_ready, 1);
        chk("t2_pop_cs", chipselect, 1);
        step();
        sb.push_back({2'b11, 13'd1234, 10'b0, 6'd40});
        in_valid = 1'b0;
        chk("t2_pushpop_level", level, 15);
        repeat (6) step();
        for (int f = 0; f < 8 && level != 0; f++) frame(n);
        chk("t2_drained", level, 0);
        chk("t2_busy", busy, 0);
        drain_cmp();
        chk("t2_sb_empty", sb.size(), 0);

        // ten entries spread over frames of at most four writes
        for (int i = 0; i < 10; i++) push(13'(100 + i), 6'(i));
        frame(n);
        chk("t3_f1_writes", n, 4);
        chk("t3_f1_level", level, 6);
        chk("t3_f1_busy", busy, 1);
        frame(n);
        chk("t3_f2_writes", n, 4);
        chk("t3_f2_level", level, 2);
        chk("t3_f2_busy", busy, 1);
        frame(n);
        chk("t3_f3_writes", n, 2);
        chk("t3_f3_level", level, 0);
        chk("t3_f3_busy", busy, 0);
        drain_cmp();

        // out-of-range indices are discarded
        push(13'd4800, 6'd5);
        push(13'd8191, 6'd1);
`ifdef TILE_WRITER_STATS_EN
        drop_exp = 2;
`endif
        step();
        chk("t4_level", level, 0);
        chk("t4_busy", busy, 0);
        frame(n);
        chk("t4_no_write", n, 0);
        chk("t4_drop", drop_count, 32'(drop_exp));

        // reset on the second write of a five-entry burst
        for (int i = 0; i < 5; i++) push(13'(200 + i), 6'(i + 1));
        vga_vs = 1'b0;
        step();
        vga_vs = 1'b1;
        chk("t5_wr1", chipselect, 1);
        step();
        chk("t5_wr2", chipselect, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_cs", chipselect, 0);
        chk("t5_write", write, 0);
        chk("t5_level", level, 0);
        chk("t5_busy", busy, 0);
        chk("t5_address", address, 0);
        chk("t5_writedata", writedata, 0);
        chk("t5_ready", in_ready, 0);
        chk("t5_drop", drop_count, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("t5_ready_back", in_ready, 1);
        drain_cmp();
        chk("t5_sb_left", sb.size(), 4);
        sb.delete();
        frame(n);
        chk("t5_no_write", n, 0);
        chk("t5_level_after", level, 0);

        // push landing on the vblank-start edge waits a frame
        in_valid = 1'b1;
        in_addr  = 13'd77;
        in_tile  = 6'd33;
        vga_vs   = 1'b0;
        step();
        in_valid = 1'b0;
        vga_vs   = 1'b1;
        sb.push_back({2'b11, 13'd77, 10'b0, 6'd33});
        chk("t6_level", level, 1);
        w0 = wr_cnt;
        repeat (6) step();
        chk("t6_no_write", wr_cnt - w0, 0);
        chk("t6_busy", busy, 1);
        frame(n);
        chk("t6_next_frame", n, 1);
        drain_cmp();
        chk("t6_busy_done", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
